// File: rtl/telem_word_sequencer.sv
// -----------------------------------------------------------------------------
// telem_word_sequencer
//
// Round-robin scheduler that places words from four telemetry data-channel
// requesters (DC1-DC4) onto one serial telemetry line. Each granted word is
// framed as: sync bit, 2-bit channel ID (MSB first), WORD_W data bits (MSB
// first), odd parity over ID+data, then a one-bit-period gap. Every bit lasts
// BIT_DIV clock cycles, paced by an internal divider.
//
// Parameters
//   WORD_W   data bits per word
//   BIT_DIV  clock cycles per serial bit period, legal range 2..255
//
// Ports
//   SIM_CLK  in   system clock, all state changes on the rising edge
//   SIM_RST  in   asynchronous active-low reset
//   ENA      in   telemetry enable, only looked at while idle
//   REQ      in   [3:0] per-channel level request, held until ACK
//   CH_DATA  in   [4*WORD_W-1:0] channel n word in bits [n*WORD_W +: WORD_W]
//   ACK      out  [3:0] one-hot single-cycle pulse, word of that channel taken
//   CHID     out  [1:0] channel of the frame in progress, holds after frame
//   TLMD     out  serial data line
//   TLMS     out  high for the whole sync bit period
//   TLMF     out  high from sync start through the end of the parity bit
//   BUSY     out  high whenever a frame or its gap is in progress
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module telem_word_sequencer #(
  parameter int unsigned WORD_W  = 26,
  parameter int unsigned BIT_DIV = 8
) (
  input  logic                  SIM_CLK,
  input  logic                  SIM_RST,
  input  logic                  ENA,
  input  logic [3:0]            REQ,
  input  logic [4*WORD_W-1:0]   CH_DATA,
  output logic [3:0]            ACK,
  output logic [1:0]            CHID,
  output logic                  TLMD,
  output logic                  TLMS,
  output logic                  TLMF,
  output logic                  BUSY
);

  // Divider is sized for the largest legal BIT_DIV.
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StId,
    StData,
    StPar,
    StGap
  } state_e;

  state_e              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [WORD_W-1:0]   sr;
  logic                par_bit;
  logic [1:0]          last_grant;

  logic                bit_end;
  logic                grant_hit;
  logic [1:0]          grant_idx;
  logic [1:0]          cand;
  logic [WORD_W-1:0]   grant_word;
  logic                grant_par;

  assign bit_end = (div_cnt == DIV_LAST);

  // Round-robin search: first set request starting just above the last grant,
  // wrapping through all four channels (the last grant itself is tried last).
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_hit && REQ[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (grant_idx == 2'(k)) begin
        grant_word = CH_DATA[k*WORD_W +: WORD_W];
      end
    end
  end

  // Odd parity: the total number of ones over ID, data and parity is odd.
  assign grant_par = ~^{grant_idx, grant_word};

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state      <= StIdle;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      par_bit    <= 1'b0;
      last_grant <= 2'd3;
      ACK        <= 4'b0000;
      CHID       <= 2'd0;
      TLMD       <= 1'b0;
      TLMS       <= 1'b0;
      TLMF       <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      ACK <= 4'b0000;

      // Every state change happens on a bit boundary, where the divider wraps
      // to zero, so the divider restarts on each state entry.
      if (state == StIdle) begin
        div_cnt <= '0;
      end else if (bit_end) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        StIdle: begin
          bit_cnt <= '0;
          if (ENA && grant_hit) begin
            state      <= StSync;
            ACK        <= 4'b0001 << grant_idx;
            CHID       <= grant_idx;
            last_grant <= grant_idx;
            sr         <= grant_word;
            par_bit    <= grant_par;
            TLMD       <= 1'b1;
            TLMS       <= 1'b1;
            TLMF       <= 1'b1;
            BUSY       <= 1'b1;
          end
        end

        StSync: begin
          if (bit_end) begin
            state   <= StId;
            TLMS    <= 1'b0;
            TLMD    <= CHID[1];
            bit_cnt <= '0;
          end
        end

        StId: begin
          if (bit_end) begin
            if (bit_cnt == '0) begin
              TLMD    <= CHID[0];
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              // Present the data MSB and shift it out of SR in the same step.
              state   <= StData;
              TLMD    <= sr[WORD_W-1];
              sr      <= sr << 1;
              bit_cnt <= '0;
            end
          end
        end

        StData: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              state   <= StPar;
              TLMD    <= par_bit;
              bit_cnt <= '0;
            end else begin
              TLMD    <= sr[WORD_W-1];
              sr      <= sr << 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        StPar: begin
          if (bit_end) begin
            state <= StGap;
            TLMD  <= 1'b0;
            TLMF  <= 1'b0;
          end
        end

        StGap: begin
          if (bit_end) begin
            state <= StIdle;
            BUSY  <= 1'b0;
          end
        end

        default: begin
          state <= StIdle;
          TLMD  <= 1'b0;
          TLMS  <= 1'b0;
          TLMF  <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/telem_word_sequencer.md
# telem_word_sequencer

Arbitrates four telemetry data-channel requesters (DC1–DC4 sources) onto the single serial telemetry output line. It frames each granted 26-bit word as sync, channel ID, data and odd parity, and paces the frame with an internal bit-period divider. It sits between the channel-gate logic and the telemetry line driver. It replaces ad-hoc per-channel gating with one round-robin scheduler.

## Interface
- WORD_W, 26: data bits per word.
- BIT_DIV, 8: clock cycles per serial bit period; legal range 2..255.
- SIM_CLK  in  1  system clock; all state changes on rising edge.
- SIM_RST  in  1  one clock; reset is asynchronous and active-low.
- ENA  in  1  telemetry enable; sampled only in IDLE.
- REQ  in  4  per-channel word request; bit n = channel n; level, held until ACK.
- CH_DATA  in  4*WORD_W  packed words; channel n in bits [n*WORD_W +: WORD_W].
- ACK  out  4  one-hot, one-cycle pulse: word of that channel captured.
- CHID  out  2  channel ID of frame in progress; holds last value after frame.
- TLMD  out  1  serial data line.
- TLMS  out  1  high for the whole sync bit period.
- TLMF  out  1  high from sync start through end of parity bit.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SYNC, ID, DATA, PAR, GAP.
- IDLE:
  - If ENA=1 and any REQ bit is set, round-robin selects the first set bit searching upward (wrapping) from last_grant+1.
  - In the same cycle the block captures the CH_DATA slice into shift register SR and the index into CHID, computes PAR_BIT = ~^{ID, word} (odd parity over ID+data), and moves to SYNC.
  - last_grant is reset to 3, so channel 0 wins first.
- SYNC: TLMD=1, TLMS=1, one bit period.
- ID: 2 bits, CHID MSB first.
- DATA: WORD_W bits of SR, MSB first; SR shifts left once per bit period.
- PAR: 1 bit, PAR_BIT.
- GAP: TLMD=0, TLMF=0, one bit period, then IDLE.
- Bit divider: counts 0..BIT_DIV-1 and restarts on every state entry. The bit boundary is at count BIT_DIV-1. A bit counter sized for WORD_W tracks ID/DATA position.
- ENA deasserted mid-frame: the current frame and GAP complete normally; no new grant.
- REQ dropped before capture: not granted, no ACK. REQ changes after capture do not affect the frame in progress.
- A REQ still high after its ACK is a new request and competes in the next IDLE arbitration.
- Reset (SIM_RST low, any time): all outputs 0 immediately, CHID=0, state IDLE, divider and bit counter 0, SR=0, last_grant=3.
- Reset release: the first arbitration is allowed on the first rising edge with SIM_RST high.

## Timing
- All outputs are registered.
- Cycle 0: IDLE with a valid request at the edge.
- Cycle 1: ACK pulses for exactly one cycle. TLMF, TLMS, TLMD and BUSY go to 1.
- Frame length is (WORD_W+4)*BIT_DIV cycles, which is 30*BIT_DIV at the default. GAP adds BIT_DIV cycles.
- Back-to-back requests: minimum spacing between ACKs is (WORD_W+5)*BIT_DIV + 1 cycles (249 at the defaults).
- TLMD is stable for each full bit period and changes only on bit boundaries.
- TLMS falls when ID starts. TLMF falls when GAP starts. BUSY falls when IDLE is re-entered.

## Test plan
- BIT_DIV=4, REQ=0100, channel 2 word 0x0000000:
  - ACK=0100 at cycle 1, CHID=2.
  - Line sequence is 1, 1,0, twenty-six 0s, parity 0, then GAP 0.
  - TLMF high for 120 cycles; BUSY returns low 124 cycles after ACK.
- REQ=0001, channel 0 word 0x3FFFFFF: ID 00, twenty-six 1s, parity 1.
- REQ=1111 held continuously, words distinct: grant order is 0,1,2,3,0, with each ACK spaced 125 cycles apart at BIT_DIV=4.
- ENA=0 with REQ=0010: no ACK, BUSY=0. Raising ENA gives ACK=0010 one cycle later. Dropping ENA mid-frame lets the frame finish, then the block idles.
- REQ pulsed high then low while another frame runs: no ACK for that channel once the frame ends.
- SIM_RST asserted during DATA: all outputs 0 immediately. After release, REQ=1000 and REQ=0001 together gives channel 0 the grant first.
